// File: rtl/dat_address_decoder.sv
// 6809 address decoder with a 16-entry Dynamic Address Translation page table,
// qualified chip selects and an S100 MRDY wait-state generator.
module dat_address_decoder #(
  parameter int                     PHYS_WIDTH  = 20,
  parameter logic [PHYS_WIDTH-1:0]  S100_BASE   = 20'h80000,
  parameter logic [15:0]            CTRL_ADDR   = 16'hE200,
  parameter logic [15:0]            USB_BASE    = 16'hE010,
  parameter int                     WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           address,
  input  logic [7:0]            dataIn,
  input  logic                  E,
  input  logic                  readNotWrite,
  output logic [PHYS_WIDTH-1:0] physAddress,
  output logic                  romSelect,
  output logic                  ramSelect,
  output logic                  s100MemSelect,
  output logic                  swtpIoSelect,
  output logic                  s100IoSelect,
  output logic                  fpgaIoSelect,
  output logic                  usbSelect,
  output logic                  datEnabled,
  output logic                  mrdy
);

  localparam int          DAT_W     = PHYS_WIDTH - 12;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [15:0] USB_LAST  = USB_BASE + 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  function automatic logic [DAT_W-1:0] to_entry(input logic [7:0] d);
    logic [DAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < DAT_W; i++) begin
      if (i < 8) r[i] = d[i];
    end
    return r;
  endfunction

  logic             eDly_q;
  logic             eRise;
  logic             eFall;
  logic [DAT_W-1:0] dat_q [16];
  logic             datEn_q;
  logic             wrPend_q;
  logic [15:0]      wrAddr_q;
  logic [7:0]       wrData_q;
  logic             wrDat;
  logic             wrCtl;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mrdy_q, mrdy_d;

  logic [3:0]            page;
  logic [7:0]            hiByte;
  logic                  noXlate;
  logic [PHYS_WIDTH-1:0] physAddr;
  logic                  usbHit;
  logic                  memRegion;
  logic                  romSel, ramSel, s100MemSel, swtpSel, s100IoSel, fpgaSel, usbSel;

  assign eRise = E & ~eDly_q;
  assign eFall = ~E & eDly_q;

  // Table and control updates land on eFall so the write cycle itself still
  // decodes through the old mapping.
  assign wrDat = wrPend_q & eFall & (wrAddr_q[15:4] == 12'hFFF);
  assign wrCtl = wrPend_q & eFall & (wrAddr_q == CTRL_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eDly_q   <= 1'b0;
      wrPend_q <= 1'b0;
      datEn_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        dat_q[i] <= DAT_W'(i);
      end
    end else begin
      eDly_q <= E;
      if (eRise) begin
        wrPend_q <= ~readNotWrite;
      end else if (eFall) begin
        wrPend_q <= 1'b0;
      end
      if (wrDat) dat_q[wrAddr_q[3:0]] <= to_entry(wrData_q);
      if (wrCtl) datEn_q <= wrData_q[0];
    end
  end

  // Write address/data are qualified by wrPend_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (eRise && !readNotWrite) wrAddr_q <= address;
    if (E) wrData_q <= dataIn;
  end

  assign page    = address[15:12];
  assign hiByte  = address[15:8];
  assign noXlate = (page[3:1] == 3'b111);

  always_comb begin
    physAddr = {{(PHYS_WIDTH-16){1'b0}}, address};
    if (datEn_q && !noXlate) begin
      physAddr = {dat_q[page], address[11:0]};
    end
  end

  always_comb begin
    romSel     = 1'b0;
    ramSel     = 1'b0;
    s100MemSel = 1'b0;
    swtpSel    = 1'b0;
    s100IoSel  = 1'b0;
    fpgaSel    = 1'b0;
    usbSel     = 1'b0;
    usbHit     = (address == USB_BASE) || (address == USB_LAST);
    memRegion  = (page <= 4'hD) || ((page == 4'hE) && (address[11:8] >= 4'h4));
    if (E) begin
      if (usbHit) begin
        usbSel = 1'b1;
      end else if (page == 4'hF) begin
        romSel = readNotWrite;
      end else if (hiByte == 8'hE0) begin
        swtpSel = 1'b1;
      end else if (hiByte == 8'hE1) begin
        s100IoSel = 1'b1;
      end else if (hiByte == 8'hE2) begin
        fpgaSel = 1'b1;
      end else if (memRegion) begin
        if (physAddr >= S100_BASE) s100MemSel = 1'b1;
        else                       ramSel     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mrdy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mrdy_q  <= mrdy_d;
    end
  end

  // HOLD keeps a stretched E from retriggering until it finally falls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mrdy_d  = mrdy_q;
    case (state_q)
      ST_IDLE: begin
        mrdy_d = 1'b1;
        if (eRise && (s100MemSel || s100IoSel) && (WAIT_CYCLES > 0)) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
          mrdy_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (eFall) begin
          state_d = ST_IDLE;
          mrdy_d  = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          mrdy_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        mrdy_d = 1'b1;
        if (eFall) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        mrdy_d  = 1'b1;
      end
    endcase
  end

  assign physAddress   = physAddr;
  assign romSelect     = romSel;
  assign ramSelect     = ramSel;
  assign s100MemSelect = s100MemSel;
  assign swtpIoSelect  = swtpSel;
  assign s100IoSelect  = s100IoSel;
  assign fpgaIoSelect  = fpgaSel;
  assign usbSelect     = usbSel;
  assign datEnabled    = datEn_q;
  assign mrdy          = mrdy_q;

endmodule

// File: tb/tb_dat_address_decoder.sv
// Directed table-driven bench for dat_address_decoder plus reset/abort sequences.
module tb_dat_address_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic [7:0]  dataIn;
  logic        E;
  logic        readNotWrite;
  logic [19:0] physAddress;
  logic        romSelect, ramSelect, s100MemSelect, swtpIoSelect;
  logic        s100IoSelect, fpgaIoSelect, usbSelect, datEnabled, mrdy;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] ROM  = 7'b1000000;
  localparam logic [6:0] RAM  = 7'b0100000;
  localparam logic [6:0] SMEM = 7'b0010000;
  localparam logic [6:0] SWTP = 7'b0001000;
  localparam logic [6:0] SIO  = 7'b0000100;
  localparam logic [6:0] FPGA = 7'b0000010;
  localparam logic [6:0] USB  = 7'b0000001;

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  data;
    logic [19:0] phys;
    logic [6:0]  sel;
    int          lows;
    logic        den;
  } vec_t;

  vec_t vecs[$];

  dat_address_decoder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .dataIn       (dataIn),
    .E            (E),
    .readNotWrite (readNotWrite),
    .physAddress  (physAddress),
    .romSelect    (romSelect),
    .ramSelect    (ramSelect),
    .s100MemSelect(s100MemSelect),
    .swtpIoSelect (swtpIoSelect),
    .s100IoSelect (s100IoSelect),
    .fpgaIoSelect (fpgaIoSelect),
    .usbSelect    (usbSelect),
    .datEnabled   (datEnabled),
    .mrdy         (mrdy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] sels();
    return {romSelect, ramSelect, s100MemSelect, swtpIoSelect,
            s100IoSelect, fpgaIoSelect, usbSelect};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] a, input logic r, input logic [7:0] d,
                     input logic [19:0] p, input logic [6:0] s, input int l, input logic e);
    vec_t v;
    v.addr = a; v.rnw = r; v.data = d; v.phys = p; v.sel = s; v.lows = l; v.den = e;
    vecs.push_back(v);
  endtask

  // One bus cycle with E high for six clks; decode is sampled one clk into E.
  task automatic bus_cycle(input logic [15:0] a, input logic r, input logic [7:0] d,
                           output logic [19:0] p, output logic [6:0] s,
                           output logic den, output int lows);
    @(negedge clk);
    address = a; readNotWrite = r; dataIn = d; E = 1'b1;
    lows = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        p = physAddress; s = sels(); den = datEnabled;
      end
      if (mrdy == 1'b0) lows++;
    end
    E = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic simple(input logic [15:0] a, input logic r, input logic [7:0] d);
    logic [19:0] p; logic [6:0] s; logic den; int l;
    bus_cycle(a, r, d, p, s, den, l);
  endtask

  initial begin
    logic [19:0] p;
    logic [6:0]  s;
    logic        den;
    int          lows;

    add(16'h1234, 1, 8'h00, 20'h01234, RAM,  0, 0);
    add(16'hFFF1, 0, 8'h85, 20'h0FFF1, NONE, 0, 0);
    add(16'hE200, 0, 8'h01, 20'h0E200, FPGA, 0, 0);
    add(16'h1234, 1, 8'h00, 20'h85234, SMEM, 2, 1);
    add(16'hFFFE, 0, 8'h42, 20'h0FFFE, NONE, 0, 1);
    add(16'hE010, 1, 8'h00, 20'h0E010, USB,  0, 1);
    add(16'hE011, 1, 8'h00, 20'h0E011, USB,  0, 1);
    add(16'hE012, 1, 8'h00, 20'h0E012, SWTP, 0, 1);
    add(16'hFFFE, 1, 8'h00, 20'h0FFFE, ROM,  0, 1);
    add(16'hE150, 1, 8'h00, 20'h0E150, SIO,  2, 1);
    add(16'hE350, 1, 8'h00, 20'h0E350, NONE, 0, 1);
    add(16'hE400, 1, 8'h00, 20'h0E400, RAM,  0, 1);
    add(16'h0050, 1, 8'h00, 20'h00050, RAM,  0, 1);
    add(16'hFFF3, 0, 8'h20, 20'h0FFF3, NONE, 0, 1);
    add(16'h3ABC, 1, 8'h00, 20'h20ABC, RAM,  0, 1);
    add(16'hFFF4, 0, 8'h80, 20'h0FFF4, NONE, 0, 1);
    add(16'h4001, 1, 8'h00, 20'h80001, SMEM, 2, 1);
    add(16'hFFF5, 0, 8'h7F, 20'h0FFF5, NONE, 0, 1);
    add(16'h5FFF, 1, 8'h00, 20'h7FFFF, RAM,  0, 1);
    add(16'hE200, 0, 8'h00, 20'h0E200, FPGA, 0, 1);
    add(16'h1234, 1, 8'h00, 20'h01234, RAM,  0, 0);
    add(16'hE200, 0, 8'h01, 20'h0E200, FPGA, 0, 0);
    add(16'h3000, 1, 8'h00, 20'h20000, RAM,  0, 1);

    reset_n = 1'b0; E = 1'b0; address = 16'h1234; readNotWrite = 1'b1; dataIn = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_mrdy", 32'(mrdy), 32'd1);
    check("reset_den",  32'(datEnabled), 32'd0);
    check("reset_phys", 32'(physAddress), 32'h01234);
    check("reset_sel",  32'(sels()), 32'(NONE));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      bus_cycle(vecs[i].addr, vecs[i].rnw, vecs[i].data, p, s, den, lows);
      check($sformatf("v%0d_phys", i), 32'(p), 32'(vecs[i].phys));
      check($sformatf("v%0d_sel", i),  32'(s), 32'(vecs[i].sel));
      check($sformatf("v%0d_den", i),  32'(den), 32'(vecs[i].den));
      check($sformatf("v%0d_mrdylow", i), 32'(lows), 32'(vecs[i].lows));
    end

    // E low gates every select
    @(negedge clk);
    address = 16'h1234; readNotWrite = 1'b1; E = 1'b0;
    @(negedge clk);
    check("elow_ram_sel", 32'(sels()), 32'(NONE));
    address = 16'hE010;
    @(negedge clk);
    check("elow_usb_sel", 32'(sels()), 32'(NONE));

    // E dropping while still in WAIT releases mrdy at once
    @(negedge clk);
    address = 16'h4001; readNotWrite = 1'b1; E = 1'b1;
    @(negedge clk);
    check("abort_wait_low", 32'(mrdy), 32'd0);
    E = 1'b0;
    @(negedge clk);
    check("abort_wait_rel", 32'(mrdy), 32'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a wait state
    address = 16'h4001; readNotWrite = 1'b1; E = 1'b1;
    @(negedge clk);
    check("rst_wait_low", 32'(mrdy), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_wait_mrdy", 32'(mrdy), 32'd1);
    check("rst_wait_den",  32'(datEnabled), 32'd0);
    check("rst_wait_phys", 32'(physAddress), 32'h04001);
    E = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    simple(16'hE200, 1'b0, 8'h01);
    bus_cycle(16'h3000, 1'b1, 8'h00, p, s, den, lows);
    check("rst_dat3_phys", 32'(p), 32'h03000);
    check("rst_dat3_den",  32'(den), 32'd1);

    // Reset before eFall drops a pending table write
    @(negedge clk);
    address = 16'hFFF2; readNotWrite = 1'b0; dataIn = 8'h90; E = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #2;
    E = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    simple(16'hE200, 1'b0, 8'h01);
    bus_cycle(16'h2345, 1'b1, 8'h00, p, s, den, lows);
    check("abort_wr_phys", 32'(p), 32'h02345);
    check("abort_wr_sel",  32'(s), 32'(RAM));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
